// File: rtl/hex_scan_mux.sv
// Scans a double-buffered 16-bit value across a 4-digit common-anode display.
// Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module hex_scan_mux #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  an,
  output logic [1:0]  dig_idx,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;
  logic          frame_tick_q, frame_tick_d;

  logic slot_end;
  logic boundary;
  logic blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
`endif

  // Scan counters and the double buffer.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    boundary  = slot_end && (idx_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d = value_in;
      if (boundary) begin
        disp_d    = value_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they match the
  // cnt/idx/disp values in force during the cycle they are visible.
  always_comb begin
    case (idx_d)
      2'd0:    nib_d = disp_d[3:0];
      2'd1:    nib_d = disp_d[7:4];
      2'd2:    nib_d = disp_d[11:8];
      default: nib_d = disp_d[15:12];
    endcase
    blank = (cnt_d < BLANK_END);
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd1:    lead_zero = (disp_d[15:4] == 12'h000);
      2'd2:    lead_zero = (disp_d[15:8] == 8'h00);
      2'd3:    lead_zero = (disp_d[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
    if (blank || lead_zero) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end
`else
    if (blank) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end
`endif
    frame_tick_d = (cnt_d == CNT_MAX) && (idx_d == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      shadow_q     <= 16'h0000;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      nib_q        <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      nib_q        <= nib_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign a          = nib_q[3];
  assign b          = nib_q[2];
  assign c          = nib_q[1];
  assign d          = nib_q[0];
  assign an         = an_q;
  assign dig_idx    = idx_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux with PRESCALE=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_hex_scan_mux;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 4 * PRESCALE;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic        a, b, c, d;
  logic [3:0]  an;
  logic [1:0]  dig_idx;
  logic        frame_tick;
  logic        pending;

  // {an, nibble, dig_idx, frame_tick}
  logic [10:0] exp_q[$];
  int          pos;
  int          pass_cnt;
  int          chk_cnt;

  hex_scan_mux #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .a(a), .b(b), .c(c), .d(d), .an(an), .dig_idx(dig_idx),
    .frame_tick(frame_tick), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] exp_entry(input int p, input logic [15:0] v);
    int         slot;
    int         ci;
    logic [3:0] e_an;
    logic [3:0] e_nib;
    logic [15:0] upper;
    slot  = p / PRESCALE;
    ci    = p % PRESCALE;
    upper = v >> (4 * slot);
    e_nib = upper[3:0];
    if (ci < BLANK) e_an = 4'b1111;
    else            e_an = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && upper == 16'h0000) e_an = 4'b1111;
`endif
    return {e_an, e_nib, 2'(slot), (p == FRAME - 1)};
  endfunction

  task automatic push_frame(input logic [15:0] v);
    for (int p = 0; p < FRAME; p++) exp_q.push_back(exp_entry(p, v));
  endtask

  // Compare this cycle against the scoreboard, then advance one clock.
  task automatic step_check();
    logic [10:0] exp_v;
    logic [10:0] obs;
    obs = {an, a, b, c, d, dig_idx, frame_tick};
    chk_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL scan_underflow pos=%0d: got %h required queued entry", pos, obs);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs !== exp_v)
        $display("FAIL scan pos=%0d: got an/nib/idx/tick=%h required %h", pos, obs, exp_v);
      else
        pass_cnt++;
    end
    @(posedge clk); #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic check_pending(input string nm, input logic want);
    chk_cnt++;
    if (pending !== want) $display("FAIL %s: pending=%b required %b", nm, pending, want);
    else pass_cnt++;
  endtask

  task automatic check_reset_outs(input string nm);
    chk_cnt++;
    if ({an, a, b, c, d, dig_idx, frame_tick, pending} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b0})
      $display("FAIL %s: an=%b abcd=%b%b%b%b idx=%0d tick=%b pend=%b required 1111/0000/0/0/0",
               nm, an, a, b, c, d, dig_idx, frame_tick, pending);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load = 1'b0;
    value_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_hold");
    rst_n = 1'b1;
    pos = 0;
    exp_q.delete();
    push_frame(16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      if (i == 16) check_pending("reset_pending", 1'b0);
      step_check();
    end
  endtask

  task automatic test_scan_order();
    push_frame(16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == 3);
      value_in = 16'hABCD;
      if (pos == 4) check_pending("scan_pending_set", 1'b1);
      if (pos == 30) check_pending("scan_pending_hold", 1'b1);
      step_check();
    end
    load = 1'b0;
    check_pending("scan_pending_clear", 1'b0);
    push_frame(16'hABCD);
    for (int i = 0; i < FRAME; i++) step_check();
  endtask

  task automatic test_double_buffer();
    push_frame(16'hABCD);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == 5);
      value_in = 16'h1111;
      step_check();
    end
    load = 1'b0;
    push_frame(16'h1111);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == 10) || (pos == 20);
      value_in = (pos < 16) ? 16'h2222 : 16'h3333;
      if (pos == 30) check_pending("dbuf_pending", 1'b1);
      step_check();
    end
    load = 1'b0;
    push_frame(16'h3333);
    for (int i = 0; i < FRAME; i++) step_check();
  endtask

  task automatic test_boundary_load();
    push_frame(16'h3333);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == FRAME - 1);
      value_in = 16'h5A5A;
      step_check();
    end
    load = 1'b0;
    check_pending("boundary_pending", 1'b0);
    push_frame(16'h5A5A);
    for (int i = 0; i < FRAME; i++) step_check();
  endtask

  task automatic test_reset_mid();
    push_frame(16'h5A5A);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == 12);
      value_in = 16'hABCD;
      step_check();
    end
    load = 1'b0;
    push_frame(16'hABCD);
    for (int i = 0; i < 20; i++) step_check();
    rst_n = 1'b0;
    #1;
    check_reset_outs("reset_mid_immediate");
    @(posedge clk); #1;
    check_reset_outs("reset_mid_hold");
    rst_n = 1'b1;
    pos = 0;
    exp_q.delete();
    push_frame(16'h0000);
    for (int i = 0; i < FRAME; i++) step_check();
  endtask

  task automatic test_leading_zero();
    push_frame(16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      load = (pos == $urandom_range(0, 1) + 7);
      value_in = 16'h0005;
      step_check();
    end
    load = 1'b0;
    push_frame(16'h0005);
    for (int i = 0; i < FRAME; i++) step_check();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    pos      = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_boundary_load();
    test_reset_mid();
    test_leading_zero();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
